// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell (two half adders + OR) steps
// through a WIDTH-bit addition LSB first, with a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_shifted;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             hs, hc1, hc2, cell_s, cell_c;
    logic             accept, last_bit;

    always_comb begin
        hs     = a_sh[0] ^ b_sh[0];
        hc1    = a_sh[0] & b_sh[0];
        cell_s = hs ^ carry;
        hc2    = hs & carry;
        cell_c = hc1 | hc2;

        // Shift-then-insert form stays legal for WIDTH=1.
        sum_shifted            = sum_sh >> 1;
        sum_shifted[WIDTH-1]   = cell_s;

        accept    = 1'b0;
        last_bit  = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                if (cnt == LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ADD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh  <= a_in;
                b_sh  <= b_in;
                carry <= 1'b0;
                cnt   <= '0;
            end else if (state == ADD) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                sum_sh <= sum_shifted;
                carry  <= cell_c;
                cnt    <= cnt + 1'b1;
            end
            if (last_bit) begin
                sum_out   <= sum_shifted;
                carry_out <= cell_c;
            end
        end
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances on one
// clock, table-driven additions plus hand-written handshake/reset sequences.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       busy8, done8, carry8;
    logic [7:0] sum8;
    logic       busy1, done1, carry1;
    logic [0:0] sum1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] held_sum;
    logic       held_c;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .sum_out(sum8), .carry_out(carry8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .sum_out(sum1), .carry_out(carry1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       c;
    } vec8_t;

    typedef struct {
        logic [0:0] a;
        logic [0:0] b;
        logic [0:0] sum;
        logic       c;
    } vec1_t;

    vec8_t vec8[8];
    vec1_t vec1[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge of ADD cycle 1.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    // Walks the 8 ADD cycles, optionally pulsing start with 0xFF operands
    // in cycle glitch_k, then checks the DONE cycle.
    task automatic finish8(input logic [7:0] es, input logic ec, input int glitch_k);
        for (int k = 1; k <= 8; k++) begin
            check("busy8_in_add", 32'(busy8), 32'd1);
            check("done8_in_add", 32'(done8), 32'd0);
            check("sum8_held", 32'(sum8), 32'(held_sum));
            check("carry8_held", 32'(carry8), 32'(held_c));
            if (k == glitch_k) begin
                start8 = 1'b1;
                a8 = 8'hFF;
                b8 = 8'hFF;
            end
            @(posedge clk);
            @(negedge clk);
            start8 = 1'b0;
        end
        check("done8_pulse", 32'(done8), 32'd1);
        check("busy8_at_done", 32'(busy8), 32'd0);
        check("sum8_result", 32'(sum8), 32'(es));
        check("carry8_result", 32'(carry8), 32'(ec));
        held_sum = es;
        held_c   = ec;
    endtask

    task automatic idle_step8();
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done8_cleared", 32'(done8), 32'd0);
        check("busy8_idle", 32'(busy8), 32'd0);
    endtask

    initial begin
        vec8[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
        vec8[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vec8[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        vec8[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vec8[4] = '{8'h7F, 8'h7F, 8'hFE, 1'b0};
        vec8[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vec8[6] = '{8'h55, 8'hAA, 8'hFF, 1'b0};
        vec8[7] = '{8'h01, 8'h01, 8'h02, 1'b0};
        vec1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vec1[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vec1[2] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vec1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        start8 = 1'b0; start1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
        held_sum = 8'h00;
        held_c   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_carry8", 32'(carry8), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_busy8", 32'(busy8), 32'd0);
            check("idle_done8", 32'(done8), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            launch8(vec8[i].a, vec8[i].b);
            finish8(vec8[i].sum, vec8[i].c, 0);
            idle_step8();
        end

        // Back-to-back: start held through DONE.
        launch8(8'h10, 8'h20);
        finish8(8'h30, 1'b0, 0);
        launch8(8'h80, 8'h80);
        finish8(8'h00, 1'b1, 0);
        idle_step8();

        // start pulsed mid-operation is ignored.
        launch8(8'h03, 8'h04);
        finish8(8'h07, 1'b0, 3);
        idle_step8();

        launch8(8'h81, 8'h80);
        finish8(8'h01, 1'b1, 0);
        idle_step8();

        // Reset during ADD cycle 4 discards the operation.
        launch8(8'h12, 8'h34);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("busy8_before_rst", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy8", 32'(busy8), 32'd0);
        check("midrst_done8", 32'(done8), 32'd0);
        check("midrst_sum8", 32'(sum8), 32'd0);
        check("midrst_carry8", 32'(carry8), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("postrst_done8", 32'(done8), 32'd0);
            check("postrst_busy8", 32'(busy8), 32'd0);
        end
        held_sum = 8'h00;
        held_c   = 1'b0;
        launch8(8'h12, 8'h34);
        finish8(8'h46, 1'b0, 0);
        idle_step8();

        // WIDTH=1: one ADD cycle, done on the second cycle after accept.
        for (int i = 0; i < 4; i++) begin
            start1 = 1'b1;
            a1 = vec1[i].a;
            b1 = vec1[i].b;
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            a1 = ~vec1[i].a;
            b1 = ~vec1[i].b;
            check("busy1", 32'(busy1), 32'd1);
            check("done1_early", 32'(done1), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("done1", 32'(done1), 32'd1);
            check("sum1", 32'(sum1), 32'(vec1[i].sum));
            check("carry1", 32'(carry1), 32'(vec1[i].c));
            @(posedge clk);
            @(negedge clk);
            check("done1_cleared", 32'(done1), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
